// File: rtl/reg_sequencer_if.sv
// rtl/reg_sequencer_if.sv - command, register feedback and strobe bundle for reg_sequencer
interface reg_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 4
);
   logic                  start;
   logic [2:0]            op;
   logic [CNT_WIDTH-1:0]  amount;
   logic                  fill;
   logic [DATA_WIDTH-1:0] din;
   logic                  abort;
   logic                  reg_msb;
   logic                  reg_lsb;
   logic                  cl;
   logic                  ld;
   logic                  inc;
   logic                  dec;
   logic                  sr;
   logic                  sl;
   logic                  ir;
   logic                  il;
   logic [DATA_WIDTH-1:0] reg_in;
   logic                  busy;
   logic                  done;

   modport master (
      output start, op, amount, fill, din, abort, reg_msb, reg_lsb,
      input  cl, ld, inc, dec, sr, sl, ir, il, reg_in, busy, done
   );

   modport slave (
      input  start, op, amount, fill, din, abort, reg_msb, reg_lsb,
      output cl, ld, inc, dec, sr, sl, ir, il, reg_in, busy, done
   );
endinterface

// File: rtl/reg_sequencer.sv
// rtl/reg_sequencer.sv - repeats a register control strobe a commanded number of cycles
module reg_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 4
) (
   input  logic           clk,
   input  logic           rst,
   reg_sequencer_if.slave bus
);
   localparam logic [2:0] OP_CLR  = 3'd0;
   localparam logic [2:0] OP_LOAD = 3'd1;
   localparam logic [2:0] OP_ADDN = 3'd2;
   localparam logic [2:0] OP_SUBN = 3'd3;
   localparam logic [2:0] OP_SHRN = 3'd4;
   localparam logic [2:0] OP_SHLN = 3'd5;
   localparam logic [2:0] OP_RORN = 3'd6;
   localparam logic [2:0] OP_ROLN = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nx;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [CNT_WIDTH-1:0]  load_cnt;
   logic [2:0]            op_q;
   logic                  fill_q;
   logic [DATA_WIDTH-1:0] din_q;
   logic                  run_act;

   // CLR and LOAD are single-shot regardless of the requested amount
   assign load_cnt = (bus.op == OP_CLR || bus.op == OP_LOAD) ? CNT_WIDTH'(1) : bus.amount;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         op_q   <= OP_CLR;
         fill_q <= 1'b0;
         din_q  <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && bus.start) begin
            op_q   <= bus.op;
            fill_q <= bus.fill;
            din_q  <= bus.din;
            cnt    <= load_cnt;
         end else if (state == ST_RUN && cnt > CNT_WIDTH'(1)) begin
            cnt <= cnt - CNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (bus.start) state_nx = (load_cnt == '0) ? ST_DONE : ST_RUN;
         ST_RUN:  if (bus.abort || cnt <= CNT_WIDTH'(1)) state_nx = ST_DONE;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // abort suppresses the strobe in the very cycle it is seen
   assign run_act = (state == ST_RUN) && !bus.abort;

   always_comb begin
      bus.cl  = 1'b0;
      bus.ld  = 1'b0;
      bus.inc = 1'b0;
      bus.dec = 1'b0;
      bus.sr  = 1'b0;
      bus.sl  = 1'b0;
      if (run_act) begin
         case (op_q)
            OP_CLR:           bus.cl  = 1'b1;
            OP_LOAD:          bus.ld  = 1'b1;
            OP_ADDN:          bus.inc = 1'b1;
            OP_SUBN:          bus.dec = 1'b1;
            OP_SHRN, OP_RORN: bus.sr  = 1'b1;
            OP_SHLN, OP_ROLN: bus.sl  = 1'b1;
            default:          bus.cl  = 1'b0;
         endcase
      end
   end

   always_comb begin
      bus.ir = 1'b0;
      bus.il = 1'b0;
      case (op_q)
         OP_SHRN: bus.ir = fill_q;
         OP_RORN: bus.ir = bus.reg_lsb;
         OP_SHLN: bus.il = fill_q;
         OP_ROLN: bus.il = bus.reg_msb;
         default: bus.ir = 1'b0;
      endcase
   end

   assign bus.reg_in = din_q;
   assign bus.busy   = (state != ST_IDLE);
   assign bus.done   = (state == ST_DONE);
endmodule
